// File: rtl/generador_updown_if.sv
// Button-conditioner bus: raw buttons in, command strobes and debounced levels out.
//
// Signalling: up and down are single-cycle strobes with no back-pressure.
// A consumer samples them on the rising clock edge and must act on every
// cycle they are high. They are never high together. state mirrors the
// internal control FSM for observation only.
interface generador_updown_if;
    logic       btn_up;
    logic       btn_down;
    logic       up;
    logic       down;
    logic       up_level;
    logic       down_level;
    logic [1:0] state;

    modport master (
        output btn_up, btn_down,
        input  up, down, up_level, down_level, state
    );

    modport slave (
        input  btn_up, btn_down,
        output up, down, up_level, down_level, state
    );
endinterface

// File: rtl/generador_updown.sv
// Two-button command conditioner: synchronizes and debounces the raw buttons,
// turns presses into single-cycle up/down pulses, adds hold-to-repeat and
// locks out conflicting presses. Channel 0 is up, channel 1 is down.
module generador_updown #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic           clk,
    input  logic           rst,
    generador_updown_if.slave bus
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(RMAX) + 1;

    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);
    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;
    localparam logic [1:0] S_LOCK   = 2'd3;

    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    level;
    logic [1:0]    level_d;
    logic [1:0]    rise;
    logic [CW-1:0] db_cnt [2];

    logic [1:0]    state;
    logic [1:0]    nxt_state;
    logic          act;
    logic          nxt_act;
    logic          other;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic          fire;
    logic          up_q;
    logic          down_q;

    assign raw   = {bus.btn_down, bus.btn_up};
    assign rise  = level & ~level_d;
    assign other = ~act;

    // Two-flop synchronizer per button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Previous debounced level, for press-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_d <= '0;
        end else begin
            level_d <= level;
        end
    end

    // Control FSM: first pulse on press, repeat while held, lock out when both are pressed.
    // A press on the other button wins over a simultaneous release so that it never
    // slips through unlocked.
    always_comb begin
        nxt_state = state;
        nxt_act   = act;
        timer_clr = 1'b0;
        fire      = 1'b0;
        case (state)
            S_IDLE: begin
                timer_clr = 1'b1;
                if (rise == 2'b11) begin
                    nxt_state = S_LOCK;
                end else if (rise[0]) begin
                    fire      = 1'b1;
                    nxt_act   = 1'b0;
                    nxt_state = S_DELAY;
                end else if (rise[1]) begin
                    fire      = 1'b1;
                    nxt_act   = 1'b1;
                    nxt_state = S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (rise[other]) begin
                    nxt_state = S_LOCK;
                end else if (!level[act]) begin
                    nxt_state = S_IDLE;
                end else if (timer == ((state == S_DELAY) ? DELAY_LAST : RATE_LAST)) begin
                    fire      = 1'b1;
                    timer_clr = 1'b1;
                    nxt_state = S_REPEAT;
                end
            end
            S_LOCK: begin
                if (level == 2'b00) begin
                    nxt_state = S_IDLE;
                end
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // FSM state, active channel and saturating repeat timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            act   <= 1'b0;
            timer <= '0;
        end else begin
            state <= nxt_state;
            act   <= nxt_act;
            if (timer_clr) begin
                timer <= '0;
            end else if (timer != TIMER_MAX) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Registered command pulses, one cycle each, never both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            up_q   <= fire & ~nxt_act;
            down_q <= fire & nxt_act;
        end
    end

    assign bus.up         = up_q;
    assign bus.down       = down_q;
    assign bus.up_level   = level[0];
    assign bus.down_level = level[1];
    assign bus.state      = state;
endmodule

// File: tb/tb_generador_updown.sv
// Directed bench for generador_updown with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=5. Pulse times are logged as clock-edge counts and compared to
// hand-computed expected stamps.
module tb_generador_updown;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOCK = 2'd3;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    generador_updown_if u ();

    generador_updown #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u.slave)
    );

    // Edge counter: at a falling edge, cyc equals the number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    logic [31:0] exp_up_q[$];
    logic [31:0] exp_dn_q[$];
    logic [31:0] up_log[$];
    logic [31:0] dn_log[$];
    int          both_cnt = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    always @(negedge clk) begin
        if (u.up)   up_log.push_back(32'(cyc));
        if (u.down) dn_log.push_back(32'(cyc));
        if (u.up && u.down) both_cnt++;
    end

    // Model of the 4-bit up/down counter fed by the pulses.
    logic       cnt_clr = 1'b1;
    logic [3:0] cnt4 = 4'd0;
    always @(posedge clk) begin
        if (cnt_clr)     cnt4 <= 4'd0;
        else if (u.up)   cnt4 <= cnt4 + 4'd1;
        else if (u.down) cnt4 <= cnt4 - 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_logs(input string tag);
        check({tag, "_up_count"}, 32'(up_log.size()), 32'(exp_up_q.size()));
        for (int i = 0; i < up_log.size() && i < exp_up_q.size(); i++)
            check($sformatf("%s_up_t%0d", tag, i), up_log[i], exp_up_q[i]);
        check({tag, "_dn_count"}, 32'(dn_log.size()), 32'(exp_dn_q.size()));
        for (int i = 0; i < dn_log.size() && i < exp_dn_q.size(); i++)
            check($sformatf("%s_dn_t%0d", tag, i), dn_log[i], exp_dn_q[i]);
        up_log.delete();
        dn_log.delete();
        exp_up_q.delete();
        exp_dn_q.delete();
    endtask

    int c;
    int r;

    initial begin
        u.btn_up   = 1'b0;
        u.btn_down = 1'b0;

        // Reset then idle
        rst = 1'b0;
        step(3);
        check("rst_up", 32'(u.up), 0);
        check("rst_down", 32'(u.down), 0);
        check("rst_up_level", 32'(u.up_level), 0);
        check("rst_down_level", 32'(u.down_level), 0);
        check("rst_state", 32'(u.state), 32'(S_IDLE));
        rst = 1'b1;
        step(50);
        check_logs("idle");

        // Bounce rejection: 2-cycle glitches, then a clean press
        for (int i = 0; i < 5; i++) begin
            u.btn_up = 1'b1;
            step(2);
            u.btn_up = 1'b0;
            step(2);
        end
        u.btn_up = 1'b1;
        c = cyc;
        step(5);
        check("bounce_level_pre", 32'(u.up_level), 0);
        step(1);
        check("bounce_level_on", 32'(u.up_level), 1);
        check("bounce_up_pre", 32'(u.up), 0);
        step(1);
        check("bounce_up_pulse", 32'(u.up), 1);
        step(3);
        u.btn_up = 1'b0;
        step(25);
        exp_up_q.push_back(32'(c + 7));
        check_logs("bounce");

        // Hold repeat: release lands so that the ninth repeat slot is cut off
        u.btn_down = 1'b1;
        c = cyc;
        step(55);
        u.btn_down = 1'b0;
        step(5);
        check("hold_level_still", 32'(u.down_level), 1);
        step(1);
        check("hold_level_fall", 32'(u.down_level), 0);
        step(30);
        exp_dn_q.push_back(32'(c + 7));
        for (int k = 0; k < 7; k++) exp_dn_q.push_back(32'(c + 27 + 5 * k));
        check_logs("hold");

        // Conflict: up held, down joins, both released together
        u.btn_up = 1'b1;
        c = cyc;
        step(10);
        u.btn_down = 1'b1;
        step(10);
        check("conflict_lock", 32'(u.state), 32'(S_LOCK));
        step(20);
        u.btn_up   = 1'b0;
        u.btn_down = 1'b0;
        step(12);
        check("conflict_idle", 32'(u.state), 32'(S_IDLE));
        check("conflict_down_level", 32'(u.down_level), 0);
        step(10);
        exp_up_q.push_back(32'(c + 7));
        check_logs("conflict");

        // Reset while a repeat pulse is high
        u.btn_up = 1'b1;
        c = cyc;
        step(32);
        #2 rst = 1'b0;
        #1;
        check("midrst_up", 32'(u.up), 0);
        check("midrst_up_level", 32'(u.up_level), 0);
        check("midrst_state", 32'(u.state), 32'(S_IDLE));
        step(2);
        rst = 1'b1;
        r = cyc;
        step(15);
        u.btn_up = 1'b0;
        step(25);
        exp_up_q.push_back(32'(c + 7));
        exp_up_q.push_back(32'(c + 27));
        exp_up_q.push_back(32'(c + 32));
        exp_up_q.push_back(32'(r + 7));
        check_logs("midrst");

        // Counter integration: 17 ups wrap to 1, 2 downs wrap to 15
        cnt_clr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            u.btn_up = 1'b1;
            step(12);
            u.btn_up = 1'b0;
            step(12);
            if (i == 14) check("cnt_at_15", 32'(cnt4), 15);
            if (i == 15) check("cnt_wrap_0", 32'(cnt4), 0);
        end
        check("cnt_up_end", 32'(cnt4), 1);
        for (int i = 0; i < 2; i++) begin
            u.btn_down = 1'b1;
            step(12);
            u.btn_down = 1'b0;
            step(12);
        end
        check("cnt_down_end", 32'(cnt4), 15);
        check("cnt_up_pulses", 32'(up_log.size()), 17);
        check("cnt_dn_pulses", 32'(dn_log.size()), 2);

        check("no_overlap", 32'(both_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
